// File: rtl/branch_pkg.sv
// ============================================================================
// branch_pkg : opcode/funct3 constants, control-type and FSM enums, decode helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package branch_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int XLEN = 32;

    // NONE is the all-zero encoding so a cleared ID/EX register reads as "no control op"
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        BRANCH = 2'd1,
        JAL    = 2'd2,
        JALR   = 2'd3
    } ctrl_type;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    function automatic ctrl_type classify(input logic [6:0] opcode);
        ctrl_type t;
        case (opcode)
            OPC_BRANCH: t = BRANCH;
            OPC_JAL:    t = JAL;
            OPC_JALR:   t = JALR;
            default:    t = NONE;
        endcase
        return t;
    endfunction

    function automatic logic [XLEN-1:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    // Non-control instructions carry a zero immediate; their target is never used
    function automatic logic [XLEN-1:0] imm_for(input ctrl_type t, input logic [31:0] instr);
        logic [XLEN-1:0] imm;
        case (t)
            BRANCH:  imm = imm_b(instr);
            JAL:     imm = imm_j(instr);
            JALR:    imm = imm_i(instr);
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

`default_nettype wire

// File: rtl/Adder.sv
// ============================================================================
// Adder : 32-bit wrap-around adder shared by the pipeline datapath
// Rev 1.0
// ============================================================================
`default_nettype none

module Adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    assign y = a + b;

endmodule

`default_nettype wire

// File: rtl/branch_compare.sv
// ============================================================================
// branch_compare : conditional-branch predicate evaluated from funct3
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_compare
    import branch_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  funct3,
    output logic        taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (a == b);
            F3_BNE:  taken = (a != b);
            F3_BLT:  taken = ($signed(a) <  $signed(b));
            F3_BGE:  taken = ($signed(a) >= $signed(b));
            F3_BLTU: taken = (a <  b);
            F3_BGEU: taken = (a >= b);
            // 010/011 are reserved encodings and fall through as not-taken
            default: taken = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/execute_branch_cycle.sv
// ============================================================================
// execute_branch_cycle : ID/EX register, branch/jump resolution and 2-bubble squash FSM
// Rev 1.0   optional BRANCH_STATS_EN adds CtrlCount/TakenCount saturating counters
// ============================================================================
`default_nettype none

module execute_branch_cycle
    import branch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        FlushD,
    output logic        LinkWriteE,
    output logic [31:0] LinkDataE,
    output logic [4:0]  RdE
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] CtrlCount,
    output logic [31:0] TakenCount
`endif
);

    ctrl_type    type_d;
    logic [31:0] imm_d;

    assign type_d = classify(InstrD[6:0]);
    assign imm_d  = imm_for(type_d, InstrD);

    state_t      state;
    logic        valid_e;
    ctrl_type    type_e;
    logic [2:0]  funct3_e;
    logic [31:0] pc_e;
    logic [31:0] pcplus4_e;
    logic [31:0] rd1_e;
    logic [31:0] rd2_e;
    logic [31:0] imm_e;
    logic [4:0]  rd_e;

    // Payload is captured every edge; only valid_e decides whether it is a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            valid_e   <= 1'b0;
            type_e    <= NONE;
            funct3_e  <= '0;
            pc_e      <= '0;
            pcplus4_e <= '0;
            rd1_e     <= '0;
            rd2_e     <= '0;
            imm_e     <= '0;
            rd_e      <= '0;
        end else begin
            type_e    <= type_d;
            funct3_e  <= InstrD[14:12];
            pc_e      <= PCD;
            pcplus4_e <= PCPlus4D;
            rd1_e     <= RD1D;
            rd2_e     <= RD2D;
            imm_e     <= imm_d;
            rd_e      <= InstrD[11:7];
            case (state)
                RUN: begin
                    if (PCSrcE) begin
                        valid_e <= 1'b0;
                        state   <= SQUASH;
                    end else begin
                        valid_e <= 1'b1;
                    end
                end
                SQUASH: begin
                    valid_e <= 1'b0;
                    state   <= RUN;
                end
                default: begin
                    valid_e <= 1'b0;
                    state   <= RUN;
                end
            endcase
        end
    end

    logic        cond_taken;
    logic        is_jump;
    logic [31:0] target_base;
    logic [31:0] target_sum;

    branch_compare u_branch_compare (
        .a      (rd1_e),
        .b      (rd2_e),
        .funct3 (funct3_e),
        .taken  (cond_taken)
    );

    assign target_base = (type_e == JALR) ? rd1_e : pc_e;

    Adder u_target_adder (
        .a (target_base),
        .b (imm_e),
        .y (target_sum)
    );

    assign is_jump    = (type_e == JAL) || (type_e == JALR);
    assign PCTargetE  = (type_e == JALR) ? {target_sum[31:1], 1'b0} : target_sum;
    assign PCSrcE     = valid_e && (is_jump || ((type_e == BRANCH) && cond_taken));
    assign FlushD     = PCSrcE || (state == SQUASH);
    assign LinkWriteE = valid_e && is_jump;
    assign LinkDataE  = pcplus4_e;
    assign RdE        = rd_e;

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            CtrlCount  <= '0;
            TakenCount <= '0;
        end else begin
            if (valid_e && (type_e != NONE) && (CtrlCount != '1)) begin
                CtrlCount <= CtrlCount + 32'd1;
            end
            if (PCSrcE && (TakenCount != '1)) begin
                TakenCount <= TakenCount + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_execute_branch_cycle.sv
// ============================================================================
// tb_execute_branch_cycle : scoreboard bench, directed cases then random stream
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_execute_branch_cycle;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD, PCD, PCPlus4D, RD1D, RD2D;
    logic        PCSrcE, FlushD, LinkWriteE;
    logic [31:0] PCTargetE, LinkDataE;
    logic [4:0]  RdE;
`ifdef BRANCH_STATS_EN
    logic [31:0] CtrlCount, TakenCount;
`endif

    always #5 clk = ~clk;

    execute_branch_cycle dut (
        .clk        (clk),
        .reset      (reset),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .RD1D       (RD1D),
        .RD2D       (RD2D),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .FlushD     (FlushD),
        .LinkWriteE (LinkWriteE),
        .LinkDataE  (LinkDataE),
        .RdE        (RdE)
`ifdef BRANCH_STATS_EN
        ,
        .CtrlCount  (CtrlCount),
        .TakenCount (TakenCount)
`endif
    );

    typedef struct packed {
        logic        pcsrc;
        logic [31:0] target;
        logic        chk_target;
        logic        flush;
        logic        link;
        logic [31:0] link_data;
        logic [4:0]  rd;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          bubbles_left = 0;
    logic [31:0] model_ctrl = 0;
    logic [31:0] model_taken = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'd2, 5'd1, f3, v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'd1, 3'b000, rd, 7'b1100111};
    endfunction

    // Immediate values rebuilt from the field layout with plain signed arithmetic
    function automatic int ref_imm(input logic [31:0] ins);
        int r;
        case (ins[6:0])
            7'b1100011: r = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
                            + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            7'b1101111: r = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096
                            + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            7'b1100111: r = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
            default:    r = 0;
        endcase
        return r;
    endfunction

    function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb_;
            3'd5: return sa >= sb_;
            3'd6: return {1'b0, a} < {1'b0, b};
            3'd7: return {1'b0, a} >= {1'b0, b};
            default: return 1'b0;
        endcase
    endfunction

    // Present one instruction in decode for one cycle and predict the execute-stage view
    task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] imm;
        logic        is_br, is_jal, is_jalr;
        @(negedge clk);
        InstrD   = ins;
        PCD      = pc;
        PCPlus4D = pc + 32'd4;
        RD1D     = a;
        RD2D     = b;
        @(posedge clk);
        if (reset) begin
            is_br        = (ins[6:0] == 7'b1100011);
            is_jal       = (ins[6:0] == 7'b1101111);
            is_jalr      = (ins[6:0] == 7'b1100111);
            imm          = ref_imm(ins);
            e.rd         = ins[11:7];
            e.link_data  = pc + 32'd4;
            e.chk_target = is_br || is_jal || is_jalr;
            e.target     = is_jalr ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
            if (bubbles_left > 0) begin
                e.pcsrc = 1'b0;
                e.link  = 1'b0;
                e.flush = (bubbles_left == 2);
                bubbles_left--;
            end else begin
                e.link  = is_jal || is_jalr;
                e.pcsrc = e.link || (is_br && ref_cond(ins[14:12], a, b));
                e.flush = e.pcsrc;
                if (e.chk_target) model_ctrl++;
                if (e.pcsrc) begin
                    model_taken++;
                    bubbles_left = 2;
                end
            end
            sb.push_back(e);
        end
    endtask

    task automatic hold_reset(input int cycles);
        reset        = 1'b0;
        bubbles_left = 0;
        model_ctrl   = 0;
        model_taken  = 0;
        repeat (cycles) @(negedge clk);
        #2 reset = 1'b1;
    endtask

    // Monitor: outputs are a pure function of ID/EX state, so sample on the falling edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sb.delete();
                chk("rst_pcsrc", {31'd0, PCSrcE}, 32'd0);
                chk("rst_target", PCTargetE, 32'd0);
                chk("rst_flush", {31'd0, FlushD}, 32'd0);
                chk("rst_linkwr", {31'd0, LinkWriteE}, 32'd0);
                chk("rst_linkdata", LinkDataE, 32'd0);
                chk("rst_rd", {27'd0, RdE}, 32'd0);
            end else if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pcsrc", {31'd0, PCSrcE}, {31'd0, e.pcsrc});
                chk("flush", {31'd0, FlushD}, {31'd0, e.flush});
                chk("linkwr", {31'd0, LinkWriteE}, {31'd0, e.link});
                chk("linkdata", LinkDataE, e.link_data);
                chk("rd", {27'd0, RdE}, {27'd0, e.rd});
                if (e.chk_target) chk("target", PCTargetE, e.target);
            end
        end
    end

    initial begin : driver
        logic [31:0] ins, a, b, pc;
        int          k;
        InstrD = '0; PCD = '0; PCPlus4D = '0; RD1D = '0; RD2D = '0;
        hold_reset(3);

        // JAL straight after release: a visible redirect proves ValidE=1 on the first edge
        issue(enc_j(5'd5, 64), 32'h80, 0, 0);
        #1 chk("first_edge_jal", {31'd0, PCSrcE}, 32'd1);
        issue(NOP, 32'h84, 0, 0);
        issue(NOP, 32'h88, 0, 0);

        // BEQ taken, followed by two JALs that must be swallowed as bubbles
        issue(enc_b(3'b000, 16), 32'h100, 5, 5);
        #1 chk("beq_target", PCTargetE, 32'h110);
        issue(enc_j(5'd1, 8), 32'h104, 0, 0);
        #1 chk("squash_jal1", {31'd0, PCSrcE}, 32'd0);
        issue(enc_j(5'd1, 8), 32'h108, 0, 0);
        #1 chk("squash_jal2", {31'd0, PCSrcE}, 32'd0);

        // BNE not taken: the very next control op still executes
        issue(enc_b(3'b001, 16), 32'h200, 7, 7);
        issue(enc_j(5'd2, -8), 32'h204, 0, 0);
        #1 chk("after_bne_jal", {31'd0, PCSrcE}, 32'd1);
        issue(NOP, 32'h208, 0, 0);
        issue(NOP, 32'h20C, 0, 0);

        issue(enc_b(3'b100, 32), 32'h300, 32'hFFFF_FFFF, 32'd1);
        issue(NOP, 32'h304, 0, 0);
        issue(NOP, 32'h308, 0, 0);
        issue(enc_b(3'b110, 32), 32'h30C, 32'hFFFF_FFFF, 32'd1);
        issue(enc_b(3'b010, 32), 32'h310, 32'd3, 32'd3);

        issue(enc_jalr(5'd1, 4), 32'h44, 32'h203, 0);
        #1 chk("jalr_target", PCTargetE, 32'h206);
        issue(NOP, 32'h48, 0, 0);
        issue(NOP, 32'h4C, 0, 0);

        // JAL immediately followed by a would-be-taken BEQ, counters cleared first
        hold_reset(2);
        issue(enc_j(5'd3, 256), 32'h400, 0, 0);
        issue(enc_b(3'b000, 16), 32'h404, 9, 9);
        issue(NOP, 32'h408, 0, 0);
        issue(NOP, 32'h40C, 0, 0);
`ifdef BRANCH_STATS_EN
        #1 chk("stats_taken", TakenCount, 32'd1);
        chk("stats_ctrl", CtrlCount, 32'd1);
`endif

        // Taken branch, then reset lands while the squash is pending
        issue(enc_b(3'b000, 16), 32'h500, 1, 1);
        issue(NOP, 32'h504, 0, 0);
        #2 hold_reset(2);
        issue(enc_j(5'd4, 16), 32'h600, 0, 0);
        #1 chk("post_rst_jal", {31'd0, PCSrcE}, 32'd1);
        issue(NOP, 32'h604, 0, 0);

        for (int i = 0; i < 400; i++) begin
            k   = $urandom_range(0, 9);
            ins = $urandom;
            if (k <= 3)      ins[6:0] = 7'b1100011;
            else if (k == 4) ins[6:0] = 7'b1101111;
            else if (k == 5) ins[6:0] = 7'b1100111;
            else if (k == 6) ins = 32'd0;
            else if (ins[6:0] == 7'b1100011 || ins[6:0] == 7'b1101111 || ins[6:0] == 7'b1100111)
                ins[6:0] = 7'b0110011;
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            b  = ($urandom_range(0, 2) == 0) ? a : $urandom;
            pc = $urandom & 32'hFFFF_FFFC;
            issue(ins, pc, a, b);
        end

        repeat (3) issue(NOP, 32'h900, 0, 0);
        for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
`ifdef BRANCH_STATS_EN
        @(negedge clk);
        chk("final_ctrl", CtrlCount, model_ctrl);
        chk("final_taken", TakenCount, model_taken);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/execute_branch_cycle.md
EXECUTE_BRANCH_CYCLE -- requirements
Module: execute_branch_cycle

Interface
REQ-001 The block SHALL use clock clk and reset reset, asynchronous, active-low.
REQ-002 Ports SHALL be, one per line, as follows.
clk  input  1  pipeline clock
reset  input  1  asynchronous active-low reset
InstrD  input  32  decode-stage instruction from the IF/ID register
PCD  input  32  decode-stage PC
PCPlus4D  input  32  decode-stage PC+4
RD1D  input  32  rs1 operand read in decode
RD2D  input  32  rs2 operand read in decode
PCSrcE  output  1  redirect fetch to PCTargetE
PCTargetE  output  32  redirect target
FlushD  output  1  decode instruction is wrong-path
LinkWriteE  output  1  JAL/JALR link write request
LinkDataE  output  32  link value (PCPlus4E)
RdE  output  5  link destination register

Function
REQ-003 Decode SHALL classify InstrD[6:0]: 1100011 BRANCH, 1101111 JAL, 1100111 JALR; anything else is NONE, including 0x00000000.
REQ-004 Immediates SHALL be sign-extended: B-type for BRANCH, J-type for JAL, I-type for JALR.
REQ-005 On each clk rising edge the ID/EX register SHALL capture ValidE, type, funct3, PCE, PCPlus4E, RD1E, RD2E, ImmE and RdE (InstrD[11:7]).
REQ-006 BRANCH conditions SHALL follow funct3: 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE; funct3 010/011 SHALL evaluate not-taken.
REQ-007 PCTargetE SHALL be PCE+ImmE for BRANCH/JAL, and (RD1E+ImmE) with bit 0 cleared for JALR, using 32-bit wrap-around arithmetic.
REQ-008 PCSrcE SHALL be combinational: ValidE AND (JAL OR JALR OR (BRANCH AND condition true)).
REQ-009 FlushD SHALL equal PCSrcE OR (state == SQUASH).
REQ-010 LinkWriteE SHALL equal ValidE AND (JAL OR JALR); LinkDataE SHALL equal PCPlus4E.
REQ-011 The state machine SHALL have two states, RUN and SQUASH.
REQ-012 In RUN with PCSrcE=1, the next edge SHALL load ValidE=0 and enter SQUASH.
REQ-013 In SQUASH, the next edge SHALL load ValidE=0 and return to RUN, giving exactly two bubbles per redirect.
REQ-014 In RUN with PCSrcE=0, the next edge SHALL load ValidE=1.
REQ-015 A control instruction that arrives in decode during a SQUASH cycle SHALL be discarded and SHALL never assert PCSrcE.
REQ-016 Bubbles (ValidE=0) SHALL hold PCSrcE=0 and LinkWriteE=0 regardless of the other ID/EX fields.

Reset
REQ-017 While reset=0: state=RUN, all ID/EX fields 0, ValidE=0.
REQ-018 While reset=0, outputs SHALL be: PCSrcE=0, PCTargetE=0, FlushD=0, LinkWriteE=0, LinkDataE=0, RdE=0.
REQ-019 Reset asserted mid-SQUASH SHALL abandon the squash immediately.
REQ-020 The first edge after reset release SHALL load ValidE=1.

Configuration
REQ-021 With macro BRANCH_STATS_EN defined, the block SHALL add outputs CtrlCount[31:0] and TakenCount[31:0].
REQ-022 CtrlCount SHALL increment on each edge where ValidE=1 and type is not NONE.
REQ-023 TakenCount SHALL increment on each edge where PCSrcE=1.
REQ-024 Both counters SHALL saturate at 0xFFFFFFFF and reset to 0.
REQ-025 Without BRANCH_STATS_EN, the counter ports and logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 A shared package branch_pkg SHALL hold the opcode constants, funct3 constants, the ctrl_type enum (NONE/BRANCH/JAL/JALR) and the state enum (RUN/SQUASH).
REQ-027 The condition logic SHALL be a sub-module branch_compare (inputs a, b, funct3; output taken).
REQ-028 Target addition SHALL reuse the existing Adder module.

Verification
REQ-029 BEQ imm=+16, PCD=0x100, RD1D=RD2D=5 -> next cycle PCSrcE=1, PCTargetE=0x110, FlushD=1; the following two ID/EX loads are bubbles.
REQ-030 BNE with RD1D=RD2D=7 -> PCSrcE=0, no bubbles, ValidE stays 1.
REQ-031 BLT with RD1D=0xFFFFFFFF, RD2D=1 -> taken; BLTU with the same operands -> not taken.
REQ-032 JALR rd=x1, imm=4, RD1D=0x203, PCPlus4D=0x48 -> PCTargetE=0x206, LinkWriteE=1, LinkDataE=0x48, RdE=1.
REQ-033 JAL immediately followed by BEQ (taken operands) -> only the JAL redirects; the BEQ is squashed; TakenCount=1 and CtrlCount=1 with BRANCH_STATS_EN.
REQ-034 Taken branch, then reset asserted during SQUASH -> state=RUN, all outputs 0; after release, a non-control instruction loads ValidE=1 on the first edge.
